// File: rtl/piso_serializer_ctrl.sv
// piso_serializer_ctrl: MSB-first PISO sequencer with valid/ready load, bit-period divider, zero-gap back-to-back frames; optional even parity bit via PISO_SERIALIZER_CTRL_PARITY_EN
module piso_serializer_ctrl #(
  parameter int   DATA_WIDTH   = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  abort,
  output logic                  serial_out,
  output logic                  bit_strobe,
  output logic                  frame_active,
  output logic                  frame_done
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int DW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_WIDTH - 1);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {
    IDLE,
    SHIFT
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
    , PARITY
`endif
  } state_t;
  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BW-1:0]         r_bit;
  logic [DW-1:0]         r_div;
  logic                  w_wrap;
  logic                  w_last_bit;
  logic                  w_end;
  logic                  w_accept;
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
  logic                  r_par;
  assign w_end      = w_wrap && r_state == PARITY;
  assign serial_out = r_state == PARITY ? r_par : r_state == SHIFT ? r_shift[DATA_WIDTH-1] : IDLE_LEVEL;
`else
  assign w_end      = w_wrap && w_last_bit && r_state == SHIFT;
  assign serial_out = r_state == SHIFT ? r_shift[DATA_WIDTH-1] : IDLE_LEVEL;
`endif
  assign w_wrap       = r_div == DIV_MAX;
  assign w_last_bit   = r_bit == BIT_MAX;
  assign in_ready     = !rst && !abort && (r_state == IDLE || w_end);
  assign w_accept     = in_valid && in_ready;
  assign frame_active = r_state != IDLE;
  assign bit_strobe   = frame_active && r_div == '0;
  assign frame_done   = w_end && !abort;
  // Frame sequencer: load on accept, divide each bit period, shift at period wrap, end or chain at last period
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (abort) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_div   <= '0;
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state <= SHIFT;
      r_shift <= in_data;
      r_bit   <= '0;
      r_div   <= '0;
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
      r_par   <= ^in_data;
`endif
    end else if (r_state != IDLE) begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap && r_state == SHIFT) begin
        r_shift <= {r_shift[DATA_WIDTH-2:0], IDLE_LEVEL};
        r_bit   <= r_bit + 1'b1;
      end
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
      if (w_wrap && w_last_bit && r_state == SHIFT) r_state <= PARITY;
`endif
      if (w_end) r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_piso_serializer_ctrl.sv
// tb_piso_serializer_ctrl: two configurations (CPB=1 idle-low, CPB=3 idle-high) against a per-cycle expected-bit queue model
module tb_piso_serializer_ctrl;
  localparam int W = 8;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         vld = 1'b0;
  logic         abt = 1'b0;
  logic [W-1:0] din = '0;
  logic         rdy[2];
  logic         so[2];
  logic         stb[2];
  logic         act[2];
  logic         dn[2];
  logic [2:0]   rb[2][64];
  int           hd[2];
  int           n[2];
  logic         acc[2];
  int           checks = 0;
  int           failures = 0;
  logic [15:0]  cap0 = '0;
  always #5 clk = ~clk;
  piso_serializer_ctrl #(.DATA_WIDTH(W), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy[0]), .abort(abt),
    .serial_out(so[0]), .bit_strobe(stb[0]), .frame_active(act[0]), .frame_done(dn[0]));
  piso_serializer_ctrl #(.DATA_WIDTH(W), .CLKS_PER_BIT(3), .IDLE_LEVEL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vld), .in_ready(rdy[1]), .abort(abt),
    .serial_out(so[1]), .bit_strobe(stb[1]), .frame_active(act[1]), .frame_done(dn[1]));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Each queue entry is one expected clk cycle of a frame: {last cycle, strobe, serial bit}
  task automatic push(input int d, input logic [W-1:0] w);
    int c;
    c = d == 0 ? 1 : 3;
    for (int i = W - 1; i >= 0; i--)
      for (int k = 0; k < c; k++) begin
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
        rb[d][(hd[d] + n[d]) % 64] = {1'b0, k == 0, w[i]};
`else
        rb[d][(hd[d] + n[d]) % 64] = {i == 0 && k == c - 1, k == 0, w[i]};
`endif
        n[d]++;
      end
`ifdef PISO_SERIALIZER_CTRL_PARITY_EN
    for (int k = 0; k < c; k++) begin
      rb[d][(hd[d] + n[d]) % 64] = {k == c - 1, k == 0, ^w};
      n[d]++;
    end
`endif
  endtask
  task automatic step(input logic r, input logic v, input logic [W-1:0] d, input logic a);
    logic [2:0] h;
    logic       e_rdy;
    rst = r;
    vld = v;
    din = d;
    abt = a;
    @(negedge clk);
    for (int j = 0; j < 2; j++) begin
      if (r) n[j] = 0;
      h = n[j] > 0 ? rb[j][hd[j]] : 3'b000;
      e_rdy = !r && !a && (n[j] == 0 || h[2]);
      check($sformatf("d%0d_ready", j), 32'(rdy[j]), 32'(e_rdy));
      check($sformatf("d%0d_serial", j), 32'(so[j]), 32'(n[j] > 0 ? h[0] : (j == 1)));
      check($sformatf("d%0d_strobe", j), 32'(stb[j]), 32'(n[j] > 0 && h[1]));
      check($sformatf("d%0d_active", j), 32'(act[j]), 32'(n[j] > 0));
      check($sformatf("d%0d_done", j), 32'(dn[j]), 32'(n[j] > 0 && h[2] && !a));
      acc[j] = v && e_rdy;
    end
    cap0 = {cap0[14:0], so[0]};
    @(posedge clk);
    for (int j = 0; j < 2; j++)
      if (!r) begin
        if (n[j] > 0) begin
          hd[j] = (hd[j] + 1) % 64;
          n[j]--;
        end
        if (a) n[j] = 0;
        if (acc[j]) push(j, d);
      end
    #1;
  endtask
  task automatic idle(input int k);
    repeat (k) step(1'b0, 1'b0, W'($urandom), 1'b0);
  endtask
  initial begin
    hd = '{0, 0};
    n  = '{0, 0};
    repeat (3) step(1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 8'hA5, 1'b0);
    idle(8);
    check("a5_bits", 32'(cap0[7:0]), 32'hA5);
    idle(30);
    step(1'b0, 1'b1, 8'h81, 1'b0);
    idle(30);
    step(1'b0, 1'b1, 8'hF0, 1'b0);
    repeat (8) step(1'b0, 1'b1, 8'h0F, 1'b0);
    idle(8);
`ifndef PISO_SERIALIZER_CTRL_PARITY_EN
    check("b2b_bits", 32'(cap0), 32'hF00F);
`endif
    idle(30);
    step(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 8'h3C, 1'b0);
    idle(8);
    check("abort_next_bits", 32'(cap0[7:0]), 32'h3C);
    idle(30);
    step(1'b0, 1'b1, 8'hC3, 1'b0);
    idle(3);
    repeat (2) step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    idle(8);
    check("rst_next_bits", 32'(cap0[7:0]), 32'h55);
    idle(30);
    repeat (3000)
      step($urandom_range(0, 199) == 0, 1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 29) == 0);
    idle(40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
